bn_rr_selector_n: RTL
=====================

# bn_rr_selector_n

Parametrised N-channel data selector with a registered output and valid/ready handshakes on every input and on the output. It is the successor to the fixed four-input one-hot AND-OR selector: channel choice is made internally by a round-robin arbiter instead of an external select, and data passes through a one-entry output register. It sits between several producers and a single consumer in lab datapaths, for example switch/key sources on one side and an LED or UART sink on the other.

## Interface
Parameters:
- DATA_WIDTH, 8: width of each channel's data word.
- N_CH, 4: number of input channels; must be ≥ 2.
- CH_W, $clog2(N_CH): channel index width; derived, never overridden.

Ports:
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  N_CH  bit i set means channel i offers a word.
- in_data  in  N_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  N_CH  bit i set means channel i's word is accepted this cycle. At most one bit is set.
- out_valid  out  1  out_data and out_ch hold a word.
- out_ready  in  1  the consumer accepts the word.
- out_data  out  DATA_WIDTH  selected word, registered.
- out_ch  out  CH_W  index of the channel the word came from, registered.

## Operation
- Arbiter state is the pointer ptr (CH_W bits), which names the highest-priority channel. Priority then runs ptr, ptr+1, … up to N_CH-1 and wraps to 0.
- grant (N_CH bits, one-hot or zero) is combinational: it is the first set bit of in_valid in the priority order above. It is zero when in_valid is zero.
- can_load = !out_valid | out_ready.
- in_ready = grant & {N_CH{can_load}}.
- Data path: an AND-OR one-hot mux. Each channel word is masked with grant[i], and the masked words are ORed together. No priority encoder is used in the data path.
- Channel i is accepted when in_valid[i] & in_ready[i]. On acceptance:
  - out_data ← muxed word.
  - out_ch ← i.
  - out_valid ← 1.
  - ptr ← i+1, wrapping from N_CH-1 to 0.
- When out_valid & out_ready and nothing is accepted: out_valid ← 0. out_data and out_ch keep their old values.
- When out_valid & !out_ready (stall): out_data, out_ch and ptr hold. in_ready is all zero.
- ptr changes only on an acceptance.
- Producers must hold in_valid and in_data until accepted. The block does not depend on this.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, out_data=0, out_ch=0, ptr=0.
- in_ready is combinational from in_valid, out_valid, out_ready and ptr. in_ready is 0 while rst_n is low.
- Latency: a word accepted at edge k is presented at out_valid/out_data immediately after edge k.
- Throughput: one word per cycle while out_ready stays high. A simultaneous output pop and new acceptance in the same cycle is required to work.
- A single active channel is granted on every cycle it is valid.
- With all channels valid, grants cycle 0,1,…,N_CH-1,0.
- Reset asserted mid-transfer discards the held word. No in_ready pulse may appear while rst_n is low.
- Non-power-of-two N_CH: ptr never exceeds N_CH-1, and unused index values are never granted.

## Structure
- Shared package bn_sel_pkg:
  - clog2-style width helper.
  - Default DATA_WIDTH and N_CH constants.
  - The channel-slice indexing convention.
- Sub-module bn_rr_arbiter, parametrised by N_CH:
  - Inputs: clk, rst_n, req, advance.
  - Outputs: one-hot grant and granted index.
  - Owns ptr.
- The top module contains:
  - the AND-OR masking mux, built with a generate loop over N_CH;
  - the output register;
  - the handshake logic.

## Test plan
All scenarios use DATA_WIDTH=8, N_CH=4.
- Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0x00, out_ch=0, in_ready=0000 immediately, without waiting for a clock edge.
- Full contention: in_valid=1111, data {0x44,0x33,0x22,0x11}, out_ready=1 -> out_ch sequence 0,1,2,3,0 and out_data 0x11,0x22,0x33,0x44,0x11 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles after one word is loaded -> out_data holds, in_ready=0000, ptr unchanged. When out_ready rises, the next grant follows the held channel.
- Sparse requests with wrap: ptr=3, in_valid=0101 -> channel 0 granted (wrap). Then ptr=1 -> channel 2 granted.
- Single channel: in_valid=0100 for 5 cycles, out_ready=1 -> 5 words all with out_ch=2, one per cycle, no bubbles.
- Parameter sweep: N_CH=3 and DATA_WIDTH=1, all channels valid -> out_ch sequence 0,1,2,0. A reference-model scoreboard shows no lost or duplicated words under random valid/ready.

Source files
------------

// File: rtl/bn_sel_pkg.sv
// Shared definitions for the round-robin selector family.
//   BN_DATA_WIDTH / BN_N_CH : default word width and channel count
//   bn_clog2                : index-width helper, at least 1 bit for N >= 2
//   ch_lsb                  : channel i's word sits at [ch_lsb(i,dw) +: dw]
package bn_sel_pkg;
  localparam int BN_DATA_WIDTH = 8;
  localparam int BN_N_CH       = 4;

  function automatic int bn_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int ch_lsb(input int ch, input int dw);
    return ch * dw;
  endfunction
endpackage

// File: rtl/bn_rr_selector_n_if.sv
// Handshake bundle between N producers, the selector and one consumer.
//   in_valid/in_data/in_ready : producer side, one bit / one slice per channel
//   out_valid/out_ready       : consumer handshake
//   out_data/out_ch           : registered word and its source channel
// Modports: slave = the selector, master = the environment driving it.
interface bn_rr_selector_n_if
  import bn_sel_pkg::*;
#(
  parameter  int DATA_WIDTH = BN_DATA_WIDTH,
  parameter  int N_CH       = BN_N_CH,
  localparam int CH_W       = bn_clog2(N_CH)
);
  logic [N_CH-1:0]            in_valid;
  logic [N_CH*DATA_WIDTH-1:0] in_data;
  logic [N_CH-1:0]            in_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [CH_W-1:0]            out_ch;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/bn_rr_arbiter.sv
// Round-robin arbiter. ptr names the highest-priority channel; priority runs
// ptr, ptr+1, ... wrapping at N_CH-1. On advance, ptr moves past the winner.
//   clk, rst_n : clock, async active-low reset (ptr -> 0)
//   req        : per-channel requests
//   advance    : the current grant was taken this cycle
//   grant      : one-hot winner, zero when req is zero
//   gidx       : index of the winner (0 when nothing granted)
module bn_rr_arbiter
  import bn_sel_pkg::*;
#(
  parameter  int N_CH = BN_N_CH,
  localparam int CH_W = bn_clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            advance,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] gidx
);
  logic [CH_W-1:0] ptr;
  logic [CH_W:0]   s;
  logic            found;

  // Scan from ptr; the sum carries one extra bit so that non-power-of-two
  // N_CH wraps at N_CH rather than at 2**CH_W.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    s     = '0;
    for (int k = 0; k < N_CH; k++) begin
      s = {1'b0, ptr} + (CH_W+1)'(k);
      if (s >= (CH_W+1)'(N_CH)) s = s - (CH_W+1)'(N_CH);
      if (!found && req[s[CH_W-1:0]]) begin
        found       = 1'b1;
        gidx        = s[CH_W-1:0];
        grant[gidx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (advance) ptr <= (gidx == CH_W'(N_CH-1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/bn_rr_selector_n.sv
// N-channel round-robin selector with a one-entry registered output.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave modport carrying per-channel valid/data/ready and the
//                registered out_valid/out_data/out_ch with out_ready
// A word is accepted when the output register is empty or being popped;
// pop and load in the same cycle sustain one word per clock.
module bn_rr_selector_n
  import bn_sel_pkg::*;
#(
  parameter  int DATA_WIDTH = BN_DATA_WIDTH,
  parameter  int N_CH       = BN_N_CH,
  localparam int CH_W       = bn_clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  bn_rr_selector_n_if.slave bus
);
  logic [N_CH-1:0]                 grant;
  logic [CH_W-1:0]                 gidx;
  logic [N_CH-1:0]                 rdy;
  logic [N_CH-1:0][DATA_WIDTH-1:0] masked;
  logic [DATA_WIDTH-1:0]           mux;
  logic                            can_load, accept;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [CH_W-1:0]                 out_ch;

  bn_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.in_valid),
    .advance (accept),
    .grant   (grant),
    .gidx    (gidx)
  );

  assign can_load = !out_valid | bus.out_ready;
  // rst_n gates ready so no handshake can complete while reset is held.
  assign rdy      = grant & {N_CH{can_load & rst_n}};
  assign accept   = |rdy;

  // AND-OR one-hot mux: grant is already one-hot, so no priority needed.
  for (genvar g = 0; g < N_CH; g++) begin : g_mask
    assign masked[g] = bus.in_data[ch_lsb(g, DATA_WIDTH) +: DATA_WIDTH]
                     & {DATA_WIDTH{grant[g]}};
  end

  always_comb begin
    mux = '0;
    for (int i = 0; i < N_CH; i++) mux = mux | masked[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= mux;
      out_ch    <= gidx;
    end else if (out_valid && bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_ch    = out_ch;
endmodule
